// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode field bounds, fetch FSM encoding, IF/ID entry type.
package mips_pkg;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t RUN  = 2'd0;
    localparam fetch_state_t WAIT = 2'd1;
    localparam fetch_state_t DROP = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_queue.sv
// Two-entry IF/ID FIFO; entry 0 is always the head so the decode outputs come straight from flops.
module if_queue
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  if_entry_t push_data,
    output if_entry_t head,
    output logic      full,
    output logic      empty,
    output logic [1:0] count
);

    if_entry_t  e0_q, e0_d;
    if_entry_t  e1_q, e1_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;
    logic       push_ok;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;
    assign head  = e0_q;

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = push_data;
                    else                 e1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_d = push_data;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, redirect flush, IF/ID queue.
// Optional IF_PERF_CNT_EN adds stall and flush event counters.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [31:0] id_pc4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_stall_cnt,
    output logic [31:0] if_flush_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;

    logic         req;
    logic [31:0]  addr;
    logic         q_push;
    logic         q_pop;
    logic         q_full;
    logic         q_empty;
    logic [1:0]   q_count;
    if_entry_t    q_head;
    if_entry_t    q_in;
    logic [31:0]  addr_plus4;

    logic unused_full;
    logic unused_redirect_lsb;
    assign unused_full         = q_full;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign addr_plus4 = addr + 32'd4;
    assign q_in       = '{instr: imem_rdata, pc4: addr_plus4};
    assign q_pop      = id_valid & id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        q_push  = 1'b0;
        req     = 1'b0;
        addr    = addr_q;
        unique case (state_q)
            RUN: begin
                addr = pc_q;
                req  = ~redirect_valid & ({30'b0, q_count} < DEPTH);
                if (redirect_valid) begin
                    pc_d = word_align(redirect_pc);
                end else if (req) begin
                    if (imem_ack) begin
                        q_push = 1'b1;
                        pc_d   = addr_plus4;
                    end else begin
                        state_d = WAIT;
                        addr_d  = pc_q;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (redirect_valid) begin
                    pc_d    = word_align(redirect_pc);
                    state_d = imem_ack ? RUN : DROP;
                end else if (imem_ack) begin
                    q_push  = 1'b1;
                    pc_d    = addr_plus4;
                    state_d = RUN;
                end
            end
            DROP: begin
                // Request stays on the bus until the stale ack; the PC already tracks the new target.
                req = 1'b1;
                if (redirect_valid) pc_d = word_align(redirect_pc);
                if (imem_ack) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Gating with rst_n keeps the request low for the whole asynchronous reset window.
    assign imem_req  = req & rst_n;
    assign imem_addr = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= word_align(RESET_PC);
            addr_q  <= word_align(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    if_queue u_if_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_data (q_in),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign id_valid  = ~q_empty;
    assign id_instr  = q_head.instr;
    assign id_opcode = q_head.instr[OPC_MSB:OPC_LSB];
    assign id_pc4    = q_head.pc4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        flush_hit;

    // A redirect wastes work if entries survive the pop or a live (non-stale) request is in flight.
    assign flush_hit = redirect_valid &
                       ((q_count == 2'd2) || (q_count == 2'd1 && !q_pop) || (state_q == WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (id_valid && !id_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_hit && flush_cnt_q != 32'hFFFF_FFFF) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign if_stall_cnt = stall_cnt_q;
    assign if_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected values are hand-computed constants.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] if_stall_cnt;
  logic [31:0] if_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_opcode      (id_opcode),
    .id_pc4         (id_pc4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .if_stall_cnt   (if_stall_cnt),
    .if_flush_cnt   (if_flush_cnt)
`endif
  );

  // Memory image: opcode varies with address bits [7:2], low 26 bits echo the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:2] ^ 6'b100011, a[25:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready);
    imem_ack   = ack;
    imem_rdata = rdata;
    id_ready   = ready;
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", id_valid, 1'b0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_opcode", id_opcode, 6'h0);
    check("rst_pc4", id_pc4, 32'h0);
    tick();

    // C0: first cycle out of reset, single-cycle ack
    rst_n = 1'b1;
    drive(1'b1, mem(32'h0), 1'b1);
    #1;
    check("c0_req", imem_req, 1'b1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", id_valid, 1'b0);
    tick();

    // C1
    drive(1'b1, mem(32'h4), 1'b1);
    #1;
    check("c1_valid", id_valid, 1'b1);
    check("c1_instr", id_instr, 32'h8C00_0000);
    check("c1_opcode", id_opcode, 6'b100011);
    check("c1_pc4", id_pc4, 32'h4);
    check("c1_addr", imem_addr, 32'h4);
    check("c1_req", imem_req, 1'b1);
    tick();

    // C2
    drive(1'b1, mem(32'h8), 1'b1);
    #1;
    check("c2_instr", id_instr, 32'h8800_0004);
    check("c2_opcode", id_opcode, 6'b100010);
    check("c2_pc4", id_pc4, 32'h8);
    check("c2_addr", imem_addr, 32'h8);
    tick();

    // C3: decode stalls from here for five cycles
    drive(1'b1, mem(32'hC), 1'b0);
    #1;
    check("c3_instr", id_instr, 32'h8400_0008);
    check("c3_pc4", id_pc4, 32'hC);
    check("c3_addr", imem_addr, 32'hC);
    tick();

    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      #1;
      check("stall_req", imem_req, 1'b0);
      check("stall_valid", id_valid, 1'b1);
      check("stall_instr", id_instr, 32'h8400_0008);
      check("stall_pc4", id_pc4, 32'hC);
      tick();
    end

    // C8: release; queue full so no issue this cycle
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("c8_req_full", imem_req, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("c8_stall_cnt", if_stall_cnt, 32'd5);
`endif
    tick();

    // C9: head is word at 0xC; issue 0x10 without ack
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("c9_instr", id_instr, 32'h8000_000C);
    check("c9_opcode", id_opcode, 6'b100000);
    check("c9_pc4", id_pc4, 32'h10);
    check("c9_addr", imem_addr, 32'h10);
    check("c9_req", imem_req, 1'b1);
    tick();

    // C10: waiting
    #1;
    check("c10_req", imem_req, 1'b1);
    check("c10_addr", imem_addr, 32'h10);
    tick();

    // C11: redirect to 0x100 while outstanding
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check("c11_req_held", imem_req, 1'b1);
    check("c11_addr_held", imem_addr, 32'h10);
    tick();

    // C12: DROP; stale ack arrives
    redirect_valid = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    #1;
    check("c12_valid", id_valid, 1'b0);
    check("c12_req", imem_req, 1'b1);
    check("c12_addr", imem_addr, 32'h10);
`ifdef IF_PERF_CNT_EN
    check("c12_flush_cnt", if_flush_cnt, 32'd1);
`endif
    tick();

    // C13: stale data discarded, new request at redirect target
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("c13_valid", id_valid, 1'b0);
    check("c13_req", imem_req, 1'b1);
    check("c13_addr", imem_addr, 32'h100);
    tick();

    // C14
    drive(1'b1, mem(32'h100), 1'b1);
    #1;
    check("c14_valid", id_valid, 1'b0);
    check("c14_addr", imem_addr, 32'h100);
    tick();

    // C15
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("c15_valid", id_valid, 1'b1);
    check("c15_instr", id_instr, 32'h8C00_0100);
    check("c15_pc4", id_pc4, 32'h104);
    check("c15_addr", imem_addr, 32'h104);
    tick();

    // C16: redirect and ack together; unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    drive(1'b1, 32'h1234_5678, 1'b1);
    #1;
    check("c16_valid", id_valid, 1'b0);
    check("c16_addr", imem_addr, 32'h104);
    tick();

    // C17
    redirect_valid = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("c17_valid", id_valid, 1'b0);
    check("c17_addr", imem_addr, 32'h200);
    check("c17_req", imem_req, 1'b1);
`ifdef IF_PERF_CNT_EN
    check("c17_flush_cnt", if_flush_cnt, 32'd2);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    check("c17_req_redir", imem_req, 1'b0);
    tick();

    // C18: fetch at the top of the address space
    redirect_valid = 1'b0;
    drive(1'b1, mem(32'hFFFF_FFFC), 1'b1);
    #1;
    check("c18_addr", imem_addr, 32'hFFFF_FFFC);
    check("c18_req", imem_req, 1'b1);
`ifdef IF_PERF_CNT_EN
    check("c18_flush_cnt", if_flush_cnt, 32'd2);
`endif
    tick();

    // C19: wrapped pc4, next fetch at 0
    drive(1'b1, mem(32'h0), 1'b0);
    #1;
    check("c19_instr", id_instr, 32'h73FF_FFFC);
    check("c19_opcode", id_opcode, 6'b011100);
    check("c19_pc4", id_pc4, 32'h0);
    check("c19_addr", imem_addr, 32'h0);
    tick();

    // C20: queue full, pop one
    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("c20_req", imem_req, 1'b0);
    tick();

    // C21: issue 0x4, no ack
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("c21_instr", id_instr, 32'h8C00_0000);
    check("c21_addr", imem_addr, 32'h4);
    tick();

    // C22: async reset while waiting with a queued entry and an ack on the bus
    drive(1'b1, 32'hCAFE_F00D, 1'b1);
    #1;
    check("c22_pre_valid", id_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("c22_rst_valid", id_valid, 1'b0);
    check("c22_rst_req", imem_req, 1'b0);
    check("c22_rst_addr", imem_addr, 32'h0);
    check("c22_rst_instr", id_instr, 32'h0);
    tick();

    rst_n = 1'b1;
    drive(1'b1, mem(32'h0), 1'b1);
    #1;
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", id_valid, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("post_rst_stall", if_stall_cnt, 32'd0);
    check("post_rst_flush", if_flush_cnt, 32'd0);
`endif
    tick();

    drive(1'b0, 32'h0, 1'b1);
    #1;
    check("post_rst_instr", id_instr, 32'h8C00_0000);
    check("post_rst_pc4", id_pc4, 32'h4);
    check("post_rst_addr2", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction-fetch stage directly upstream of the decode/control stage.
- Owns the program counter and issues word requests to instruction memory over a single-outstanding req/ack handshake.
- Buffers returned words in a 2-entry IF/ID queue and presents them to decode with the opcode field split out for the control unit.
- Supports `jr` redirects from downstream, flushing stale instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, IF/ID queue entries; fixed at 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- id_valid  out  1  id_instr/id_pc4/id_opcode valid.
- id_ready  in  1  decode accepts the head entry.
- id_instr  out  32  instruction word.
- id_opcode  out  6  id_instr[31:26], feeds the control unit.
- id_pc4  out  32  fetch address + 4.
- redirect_valid  in  1  branch/jr taken, one-cycle pulse.
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0).

## Operation
- FSM states:
  - RUN: may issue a request.
  - WAIT: request outstanding, imem_req held.
  - DROP: outstanding request is stale; its response is discarded.
- Issue rule: in RUN, imem_req=1 when (queue occupancy + outstanding) < 2 and no redirect this cycle.
- imem_req and imem_addr stay stable until imem_ack; there is no abort.
- Accept on ack in WAIT: push {rdata, addr+4}; pc <= pc+4; go to RUN.
- Ack in the same cycle as request issue is legal and counts as WAIT+ack.
- Redirect on cycle N:
  - Queue is cleared.
  - pc <= {redirect_pc[31:2],2'b00}.
  - If a request is outstanding and not acked on cycle N, go to DROP.
  - An ack arriving on cycle N is discarded.
- DROP: on ack, discard the data and go to RUN; the next request uses the redirected pc.
- A redirect in DROP only updates pc and stays in DROP.
- Pop: on id_valid && id_ready. A pop and redirect in the same cycle complete the pop (the branch itself leaves); the remainder is flushed.
- Push and pop in the same cycle with a full queue is legal; occupancy is unchanged.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, id_valid=0.
  - id_instr=0, id_opcode=0, id_pc4=0.
  - Queue empty, state RUN.
- First cycle after rst_n deasserts: imem_req=1, imem_addr=RESET_PC.
- Ack on cycle N: id_valid=1 on N+1 (registered output). Best-case issue-to-decode latency is 1 cycle after ack.
- Throughput: 1 instruction/cycle with a single-cycle-ack memory and id_ready held high.
- Redirect on N: id_valid=0 on N+1. First new request on N+1 if nothing is outstanding, else the cycle after the stale ack.
- Reset asserted mid-operation: all state clears immediately (async); any in-flight response is ignored.
- Outputs are stable while id_valid && !id_ready.

## Configuration
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds out port if_stall_cnt[31:0]: counts cycles with id_valid && !id_ready.
  - Adds out port if_flush_cnt[31:0]: counts redirects that discarded ≥1 queued or in-flight instruction.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

## Structure
- Shared package mips_pkg:
  - Opcode field range constants (OPC_MSB=31, OPC_LSB=26).
  - Fetch FSM state enum {RUN, WAIT, DROP}.
  - Typedef if_entry_t {instr[31:0], pc4[31:0]}.
  - RESET_PC default.
- One sub-module, if_queue: 2-entry FIFO of if_entry_t with push, pop, flush, full, empty and count.
- Top level holds the PC, FSM, issue logic and counters.

## Test plan
- Reset, then single-cycle acks, id_ready=1 → requests to 0x0, 0x4, 0x8 on consecutive cycles; id_pc4 = 0x4, 0x8, 0xC; id_opcode = rdata[31:26] (e.g. 0x8C000000 → 6'b100011).
- id_ready=0 for 5 cycles → after 2 acks imem_req=0, id_valid=1, outputs frozen. With IF_PERF_CNT_EN, if_stall_cnt=5.
- Request outstanding with ack delayed 3 cycles; redirect to 0x100 → stale word discarded, next imem_addr=0x100, id_valid=0 until the 0x100 response.
- Redirect and ack in the same cycle, redirect_pc=0x203 → ack discarded; next imem_addr=0x200.
- pc=0xFFFF_FFFC fetched → id_pc4=0x0, next imem_addr=0x0.
- Assert rst_n low while WAIT and queue full → id_valid=0 and imem_req=0 immediately; after release, first request to RESET_PC.
